// File: rtl/dual_issue_scheduler.sv
// Dual-issue scheduler: issues a fetched pair together or splits it (A now, B from a hold buffer next accepted cycle).
// Optional build macro SCHED_PERF_CNT_EN adds the saturating pair_cnt / split_cnt performance counters.
module dual_issue_scheduler #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            fetch_valid,
  input  logic [XLEN-1:0] pc_a,
  input  logic [XLEN-1:0] pc_b,
  input  logic [XLEN-1:0] instr_a,
  input  logic [XLEN-1:0] instr_b,
  input  logic            issue_ready,
  input  logic            flush,
  output logic            stall_f,
  output logic            iss_valid_a,
  output logic            iss_valid_b,
  output logic [XLEN-1:0] iss_pc_a,
  output logic [XLEN-1:0] iss_pc_b,
  output logic [XLEN-1:0] iss_instr_a,
  output logic [XLEN-1:0] iss_instr_b
`ifdef SCHED_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] pair_cnt,
  output logic [CNT_W-1:0] split_cnt
`endif
);

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [0:0] {
    ST_PAIR   = 1'b0,
    ST_HOLD_B = 1'b1
  } state_e;

  function automatic logic op_writes_rd(input logic [6:0] op);
    case (op)
      OPC_STORE, OPC_BRANCH: return 1'b0;
      default:               return 1'b1;
    endcase
  endfunction

  function automatic logic op_uses_rs1(input logic [6:0] op);
    case (op)
      OPC_LUI, OPC_AUIPC, OPC_JAL: return 1'b0;
      default:                     return 1'b1;
    endcase
  endfunction

  function automatic logic op_uses_rs2(input logic [6:0] op);
    case (op)
      OPC_STORE, OPC_BRANCH, OPC_OP: return 1'b1;
      default:                       return 1'b0;
    endcase
  endfunction

  function automatic logic op_is_mem(input logic [6:0] op);
    case (op)
      OPC_LOAD, OPC_STORE: return 1'b1;
      default:             return 1'b0;
    endcase
  endfunction

  function automatic logic op_is_ctrl(input logic [6:0] op);
    case (op)
      OPC_BRANCH, OPC_JAL, OPC_JALR: return 1'b1;
      default:                       return 1'b0;
    endcase
  endfunction

  state_e            state_r;
  state_e            state_nxt_s;
  logic              buf_valid_r;
  logic [XLEN-1:0]   buf_pc_r;
  logic [XLEN-1:0]   buf_instr_r;

  logic              a_nz_s;
  logic              b_nz_s;
  logic [6:0]        op_a_s;
  logic [6:0]        op_b_s;
  logic [4:0]        rd_a_s;
  logic [4:0]        rs1_b_s;
  logic [4:0]        rs2_b_s;
  logic              raw_s;
  logic              mem_s;
  logic              ctrl_s;
  logic              conflict_s;
  logic              take_s;
  logic              release_s;
  logic              idle_s;

  // Intra-pair conflict detection; a zero instruction in either slot disables every rule.
  always_comb begin
    a_nz_s  = (instr_a != {XLEN{1'b0}});
    b_nz_s  = (instr_b != {XLEN{1'b0}});
    op_a_s  = instr_a[6:0];
    op_b_s  = instr_b[6:0];
    rd_a_s  = instr_a[11:7];
    rs1_b_s = instr_b[19:15];
    rs2_b_s = instr_b[24:20];
    raw_s   = op_writes_rd(op_a_s) && (rd_a_s != 5'd0) &&
              ((op_uses_rs1(op_b_s) && (rs1_b_s == rd_a_s)) ||
               (op_uses_rs2(op_b_s) && (rs2_b_s == rd_a_s)));
    mem_s   = op_is_mem(op_a_s) && op_is_mem(op_b_s);
    ctrl_s  = op_is_ctrl(op_a_s);
    if (a_nz_s && b_nz_s) begin
      conflict_s = raw_s || mem_s || ctrl_s;
    end else begin
      conflict_s = 1'b0;
    end
  end

  // Cycle qualifiers shared by the FSM and the issue datapath.
  always_comb begin
    take_s    = fetch_valid && issue_ready && !flush && (state_r == ST_PAIR);
    release_s = issue_ready && !flush && (state_r == ST_HOLD_B);
    idle_s    = !fetch_valid && issue_ready && !flush && (state_r == ST_PAIR);
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_PAIR;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next state and fetch stall; flush overrides everything and never stalls.
  always_comb begin
    state_nxt_s = state_r;
    stall_f     = 1'b0;
    if (flush) begin
      state_nxt_s = ST_PAIR;
    end else begin
      case (state_r)
        ST_PAIR: begin
          if (take_s && conflict_s) begin
            stall_f     = 1'b1;
            state_nxt_s = ST_HOLD_B;
          end else begin
            state_nxt_s = ST_PAIR;
          end
        end
        ST_HOLD_B: begin
          if (issue_ready) begin
            state_nxt_s = ST_PAIR;
          end else begin
            stall_f     = 1'b1;
            state_nxt_s = ST_HOLD_B;
          end
        end
        default: begin
          state_nxt_s = ST_PAIR;
        end
      endcase
    end
  end

  // Issue registers and hold buffer: accept a pair, split it, release held B, or flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iss_valid_a <= 1'b0;
      iss_valid_b <= 1'b0;
      iss_pc_a    <= {XLEN{1'b0}};
      iss_pc_b    <= {XLEN{1'b0}};
      iss_instr_a <= {XLEN{1'b0}};
      iss_instr_b <= {XLEN{1'b0}};
      buf_valid_r <= 1'b0;
      buf_pc_r    <= {XLEN{1'b0}};
      buf_instr_r <= {XLEN{1'b0}};
    end else if (flush) begin
      iss_valid_a <= 1'b0;
      iss_valid_b <= 1'b0;
      buf_valid_r <= 1'b0;
    end else if (take_s) begin
      iss_pc_a    <= pc_a;
      iss_instr_a <= instr_a;
      iss_valid_a <= a_nz_s;
      if (conflict_s) begin
        iss_valid_b <= 1'b0;
        buf_valid_r <= 1'b1;
        buf_pc_r    <= pc_b;
        buf_instr_r <= instr_b;
      end else begin
        iss_pc_b    <= pc_b;
        iss_instr_b <= instr_b;
        iss_valid_b <= b_nz_s;
      end
    end else if (release_s) begin
      // Held B goes out alone in slot A; the pair presented this cycle is the one already split.
      iss_pc_a    <= buf_pc_r;
      iss_instr_a <= buf_instr_r;
      iss_valid_a <= buf_valid_r;
      iss_valid_b <= 1'b0;
      buf_valid_r <= 1'b0;
    end else if (idle_s) begin
      iss_valid_a <= 1'b0;
      iss_valid_b <= 1'b0;
    end
  end

`ifdef SCHED_PERF_CNT_EN
  logic pair_inc_s;
  logic split_inc_s;

  assign pair_inc_s  = take_s && !conflict_s && a_nz_s && b_nz_s;
  assign split_inc_s = take_s && conflict_s;

  // Saturating performance counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pair_cnt  <= {CNT_W{1'b0}};
      split_cnt <= {CNT_W{1'b0}};
    end else begin
      if (pair_inc_s && (pair_cnt != {CNT_W{1'b1}})) begin
        pair_cnt <= pair_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (split_inc_s && (split_cnt != {CNT_W{1'b1}})) begin
        split_cnt <= split_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end
`endif

endmodule

// File: tb/tb_dual_issue_scheduler.sv
// Self-checking bench for dual_issue_scheduler: directed scenarios plus randomized traffic against a queue-based model.
module tb_dual_issue_scheduler;

  localparam int XLEN  = 32;
  localparam int CNT_W = 32;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_IMM    = 7'b0010011;

  localparam logic [31:0] ADDI_X1  = 32'h00100093;
  localparam logic [31:0] ADDI_X2  = 32'h00200113;
  localparam logic [31:0] ADDI_X5  = 32'h00100293;
  localparam logic [31:0] ADD_X6   = 32'h00528333;
  localparam logic [31:0] LW_X7    = 32'h00052383;
  localparam logic [31:0] SW_X8    = 32'h0085A223;
  localparam logic [31:0] PC0      = 32'h80000000;
  localparam logic [31:0] PC1      = 32'h80000004;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            fetch_valid = 1'b0;
  logic            issue_ready = 1'b0;
  logic            flush = 1'b0;
  logic [XLEN-1:0] pc_a = 32'h0, pc_b = 32'h0, instr_a = 32'h0, instr_b = 32'h0;
  logic            stall_f, iss_valid_a, iss_valid_b;
  logic [XLEN-1:0] iss_pc_a, iss_pc_b, iss_instr_a, iss_instr_b;
`ifdef SCHED_PERF_CNT_EN
  logic [CNT_W-1:0] pair_cnt, split_cnt;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  dual_issue_scheduler #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .fetch_valid(fetch_valid),
    .pc_a(pc_a), .pc_b(pc_b), .instr_a(instr_a), .instr_b(instr_b),
    .issue_ready(issue_ready), .flush(flush), .stall_f(stall_f),
    .iss_valid_a(iss_valid_a), .iss_valid_b(iss_valid_b),
    .iss_pc_a(iss_pc_a), .iss_pc_b(iss_pc_b),
    .iss_instr_a(iss_instr_a), .iss_instr_b(iss_instr_b)
`ifdef SCHED_PERF_CNT_EN
    , .pair_cnt(pair_cnt), .split_cnt(split_cnt)
`endif
  );

  function automatic logic [31:0] mk(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'd0, rs2, rs1, 3'd0, rd, op};
  endfunction

  function automatic bit is_one_of(input logic [6:0] op, input logic [6:0] x, input logic [6:0] y, input logic [6:0] z);
    return (op == x) || (op == y) || (op == z);
  endfunction

  // Reference conflict rules, written straight from the decode table.
  function automatic bit ref_conflict(input logic [31:0] a, input logic [31:0] b);
    bit a_writes, b_reads_rd, both_mem, a_ctrl;
    if (a == 32'h0 || b == 32'h0) return 1'b0;
    a_writes   = !is_one_of(a[6:0], OPC_STORE, OPC_BRANCH, OPC_BRANCH) && (a[11:7] != 5'd0);
    b_reads_rd = (!is_one_of(b[6:0], OPC_LUI, OPC_AUIPC, OPC_JAL) && (b[19:15] == a[11:7])) ||
                 (is_one_of(b[6:0], OPC_STORE, OPC_BRANCH, OPC_OP) && (b[24:20] == a[11:7]));
    both_mem   = is_one_of(a[6:0], OPC_LOAD, OPC_STORE, OPC_STORE) && is_one_of(b[6:0], OPC_LOAD, OPC_STORE, OPC_STORE);
    a_ctrl     = is_one_of(a[6:0], OPC_BRANCH, OPC_JAL, OPC_JALR);
    return (a_writes && b_reads_rd) || both_mem || a_ctrl;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [4:0] rd, rs1, rs2;
    rd  = 5'($urandom_range(0, 3));
    rs1 = 5'($urandom_range(0, 3));
    rs2 = 5'($urandom_range(0, 3));
    case ($urandom_range(0, 10))
      0:       return 32'h0;
      1:       return mk(OPC_LOAD, rd, rs1, rs2);
      2:       return mk(OPC_STORE, rd, rs1, rs2);
      3:       return mk(OPC_BRANCH, rd, rs1, rs2);
      4:       return mk(OPC_JAL, rd, rs1, rs2);
      5:       return mk(OPC_JALR, rd, rs1, rs2);
      6:       return mk(OPC_LUI, rd, rs1, rs2);
      7:       return mk(OPC_AUIPC, rd, rs1, rs2);
      8:       return mk(OPC_OP, rd, rs1, rs2);
      default: return mk(OPC_IMM, rd, rs1, rs2);
    endcase
  endfunction

  task automatic drive(input logic fv, input logic [31:0] pa, input logic [31:0] ia,
                       input logic [31:0] pb, input logic [31:0] ib, input logic rdy, input logic fl);
    @(negedge clk);
    fetch_valid = fv; pc_a = pa; instr_a = ia; pc_b = pb; instr_b = ib;
    issue_ready = rdy; flush = fl;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1; fetch_valid = 1'b0; issue_ready = 1'b0; flush = 1'b0;
    pc_a = 32'h0; pc_b = 32'h0; instr_a = 32'h0; instr_b = 32'h0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    apply_reset();
    tests_run++; if (stall_f !== 1'b0) begin tests_failed++; $display("FAIL reset_stall: got %0b want 0", stall_f); end
    tests_run++; if ({iss_valid_a, iss_valid_b} !== 2'b00) begin tests_failed++; $display("FAIL reset_valid: got %b want 00", {iss_valid_a, iss_valid_b}); end
    tests_run++; if ({iss_pc_a, iss_instr_a, iss_pc_b, iss_instr_b} !== 128'h0) begin tests_failed++;
      $display("FAIL reset_data: got %h %h %h %h want all zero", iss_pc_a, iss_instr_a, iss_pc_b, iss_instr_b); end
  endtask

  task automatic test_indep_pair();
    apply_reset();
    drive(1'b1, PC0, ADDI_X1, PC1, ADDI_X2, 1'b1, 1'b0);
    tests_run++; if (stall_f !== 1'b0) begin tests_failed++; $display("FAIL indep_stall: got %0b want 0", stall_f); end
    tick();
    tests_run++; if ({iss_valid_a, iss_pc_a, iss_instr_a} !== {1'b1, PC0, ADDI_X1}) begin tests_failed++;
      $display("FAIL indep_a: got %0b %h %h want 1 %h %h", iss_valid_a, iss_pc_a, iss_instr_a, PC0, ADDI_X1); end
    tests_run++; if ({iss_valid_b, iss_pc_b, iss_instr_b} !== {1'b1, PC1, ADDI_X2}) begin tests_failed++;
      $display("FAIL indep_b: got %0b %h %h want 1 %h %h", iss_valid_b, iss_pc_b, iss_instr_b, PC1, ADDI_X2); end
    drive(1'b0, PC0, 32'h0, PC1, 32'h0, 1'b1, 1'b0);
    tick();
    tests_run++; if ({iss_valid_a, iss_valid_b} !== 2'b00) begin tests_failed++; $display("FAIL nofetch_valid: got %b want 00", {iss_valid_a, iss_valid_b}); end
  endtask

  task automatic test_raw_split();
    apply_reset();
    drive(1'b1, PC0, ADDI_X5, PC1, ADD_X6, 1'b1, 1'b0);
    tests_run++; if (stall_f !== 1'b1) begin tests_failed++; $display("FAIL raw_stall: got %0b want 1", stall_f); end
    tick();
    tests_run++; if ({iss_valid_a, iss_pc_a, iss_instr_a, iss_valid_b} !== {1'b1, PC0, ADDI_X5, 1'b0}) begin tests_failed++;
      $display("FAIL raw_first: got %0b %h %h vb=%0b want 1 %h %h vb=0", iss_valid_a, iss_pc_a, iss_instr_a, iss_valid_b, PC0, ADDI_X5); end
    tests_run++; if (stall_f !== 1'b0) begin tests_failed++; $display("FAIL raw_release_stall: got %0b want 0", stall_f); end
    tick();
    tests_run++; if ({iss_valid_a, iss_pc_a, iss_instr_a, iss_valid_b} !== {1'b1, PC1, ADD_X6, 1'b0}) begin tests_failed++;
      $display("FAIL raw_second: got %0b %h %h vb=%0b want 1 %h %h vb=0", iss_valid_a, iss_pc_a, iss_instr_a, iss_valid_b, PC1, ADD_X6); end
    drive(1'b1, PC0 + 32'd8, ADDI_X1, PC0 + 32'd12, ADDI_X2, 1'b1, 1'b0);
    tick();
    tests_run++; if ({iss_valid_a, iss_valid_b, iss_pc_a} !== {2'b11, PC0 + 32'd8}) begin tests_failed++;
      $display("FAIL raw_back_to_pair: got %b %h want 11 %h", {iss_valid_a, iss_valid_b}, iss_pc_a, PC0 + 32'd8); end
  endtask

  task automatic test_rules();
    logic [31:0] beq_i, addi_x0, add_x0, add_x4;
    beq_i   = mk(OPC_BRANCH, 5'd0, 5'd1, 5'd2);
    addi_x0 = mk(OPC_IMM, 5'd0, 5'd3, 5'd0);
    add_x0  = mk(OPC_OP, 5'd4, 5'd0, 5'd0);
    add_x4  = mk(OPC_OP, 5'd9, 5'd4, 5'd4);
    apply_reset();
    drive(1'b1, PC0, LW_X7, PC1, SW_X8, 1'b1, 1'b0);
    tests_run++; if (stall_f !== 1'b1) begin tests_failed++; $display("FAIL mem_stall: got %0b want 1", stall_f); end
    tick();
    tests_run++; if ({iss_valid_a, iss_valid_b} !== 2'b10) begin tests_failed++; $display("FAIL mem_split: got %b want 10", {iss_valid_a, iss_valid_b}); end
    tick();
    drive(1'b1, PC0, beq_i, PC1, ADDI_X1, 1'b1, 1'b0);
    tests_run++; if (stall_f !== 1'b1) begin tests_failed++; $display("FAIL branch_stall: got %0b want 1", stall_f); end
    tick();
    tick();
    tests_run++; if ({iss_valid_a, iss_instr_a, iss_valid_b} !== {1'b1, ADDI_X1, 1'b0}) begin tests_failed++;
      $display("FAIL branch_release: got %0b %h %0b want 1 %h 0", iss_valid_a, iss_instr_a, iss_valid_b, ADDI_X1); end
    drive(1'b1, PC0, addi_x0, PC1, add_x0, 1'b1, 1'b0);
    tests_run++; if (stall_f !== 1'b0) begin tests_failed++; $display("FAIL x0_stall: got %0b want 0", stall_f); end
    tick();
    tests_run++; if ({iss_valid_a, iss_valid_b} !== 2'b11) begin tests_failed++; $display("FAIL x0_paired: got %b want 11", {iss_valid_a, iss_valid_b}); end
    drive(1'b1, PC0, 32'h0, PC1, add_x4, 1'b1, 1'b0);
    tests_run++; if (stall_f !== 1'b0) begin tests_failed++; $display("FAIL zero_a_stall: got %0b want 0", stall_f); end
    tick();
    tests_run++; if ({iss_valid_a, iss_valid_b, iss_instr_b} !== {2'b01, add_x4}) begin tests_failed++;
      $display("FAIL zero_a_issue: got %b %h want 01 %h", {iss_valid_a, iss_valid_b}, iss_instr_b, add_x4); end
  endtask

  task automatic test_hold_not_ready();
    apply_reset();
    drive(1'b1, PC0, ADDI_X5, PC1, ADD_X6, 1'b1, 1'b0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, PC0, ADDI_X5, PC1, ADD_X6, 1'b0, 1'b0);
      tests_run++; if (stall_f !== 1'b1) begin tests_failed++; $display("FAIL hold_stall[%0d]: got %0b want 1", i, stall_f); end
      tick();
      tests_run++; if ({iss_valid_a, iss_instr_a, iss_valid_b} !== {1'b1, ADDI_X5, 1'b0}) begin tests_failed++;
        $display("FAIL hold_stable[%0d]: got %0b %h %0b want 1 %h 0", i, iss_valid_a, iss_instr_a, iss_valid_b, ADDI_X5); end
    end
    drive(1'b1, PC0, ADDI_X5, PC1, ADD_X6, 1'b1, 1'b0);
    tests_run++; if (stall_f !== 1'b0) begin tests_failed++; $display("FAIL hold_ready_stall: got %0b want 0", stall_f); end
    tick();
    tests_run++; if ({iss_valid_a, iss_pc_a, iss_instr_a} !== {1'b1, PC1, ADD_X6}) begin tests_failed++;
      $display("FAIL hold_release: got %0b %h %h want 1 %h %h", iss_valid_a, iss_pc_a, iss_instr_a, PC1, ADD_X6); end
  endtask

  task automatic test_flush_hold();
    apply_reset();
    drive(1'b1, PC0, ADDI_X5, PC1, ADD_X6, 1'b1, 1'b0);
    tick();
    drive(1'b1, PC0, ADDI_X5, PC1, ADD_X6, 1'b1, 1'b1);
    tests_run++; if (stall_f !== 1'b0) begin tests_failed++; $display("FAIL flush_stall: got %0b want 0", stall_f); end
    tick();
    tests_run++; if ({iss_valid_a, iss_valid_b} !== 2'b00) begin tests_failed++; $display("FAIL flush_valid: got %b want 00", {iss_valid_a, iss_valid_b}); end
    drive(1'b0, PC0, 32'h0, PC1, 32'h0, 1'b1, 1'b0);
    tick();
    tests_run++; if ({iss_valid_a, iss_valid_b} !== 2'b00) begin tests_failed++; $display("FAIL flush_drop_b: got %b want 00", {iss_valid_a, iss_valid_b}); end
    drive(1'b1, PC0 + 32'd16, ADDI_X1, PC0 + 32'd20, ADDI_X2, 1'b1, 1'b0);
    tick();
    tests_run++; if ({iss_valid_a, iss_valid_b} !== 2'b11) begin tests_failed++; $display("FAIL flush_then_pair: got %b want 11", {iss_valid_a, iss_valid_b}); end
  endtask

  task automatic test_async_reset();
    apply_reset();
    drive(1'b1, PC0, ADDI_X5, PC1, ADD_X6, 1'b1, 1'b0);
    tick();
    drive(1'b1, PC0, ADDI_X5, PC1, ADD_X6, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    tests_run++; if ({iss_valid_a, iss_valid_b, iss_instr_a, stall_f} !== {2'b00, 32'h0, 1'b0}) begin tests_failed++;
      $display("FAIL async_rst: got %b %h stall=%0b want 00 0 stall=0", {iss_valid_a, iss_valid_b}, iss_instr_a, stall_f); end
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, PC0, 32'h0, PC1, 32'h0, 1'b1, 1'b0);
    tick();
    tests_run++; if ({iss_valid_a, iss_valid_b} !== 2'b00) begin tests_failed++; $display("FAIL async_no_partial: got %b want 00", {iss_valid_a, iss_valid_b}); end
  endtask

  task automatic test_random();
    logic [63:0]      held_q[$];
    logic [63:0]      ent;
    logic             ev_a, ev_b, e_stall, fv, rdy, fl;
    logic [31:0]      e_pca, e_ia, e_pcb, e_ib, pa, ia, ib;
    logic [CNT_W-1:0] e_pair, e_split;
    bit               c;
    apply_reset();
    ev_a = 1'b0; ev_b = 1'b0; e_pca = 32'h0; e_ia = 32'h0; e_pcb = 32'h0; e_ib = 32'h0;
    e_pair = '0; e_split = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      pa  = PC0 + 32'($urandom_range(0, 255)) * 32'd8;
      ia  = rand_instr();
      ib  = rand_instr();
      fv  = ($urandom_range(0, 9) != 0);
      rdy = ($urandom_range(0, 3) != 0);
      fl  = ($urandom_range(0, 24) == 0);
      drive(fv, pa, ia, pa + 32'd4, ib, rdy, fl);
      c = ref_conflict(ia, ib);
      if (fl) e_stall = 1'b0;
      else if (held_q.size() != 0) e_stall = !rdy;
      else e_stall = fv && rdy && c;
      if (fl || held_q.size() != 0 || rdy) begin
        tests_run++; if (stall_f !== e_stall) begin tests_failed++; $display("FAIL rand_stall[%0d]: got %0b want %0b", cyc, stall_f, e_stall); end
      end
      if (fl) begin
        ev_a = 1'b0; ev_b = 1'b0; held_q.delete();
      end else if (rdy && held_q.size() != 0) begin
        ent = held_q.pop_front();
        {e_pca, e_ia} = ent; ev_a = 1'b1; ev_b = 1'b0;
      end else if (rdy && !fv) begin
        ev_a = 1'b0; ev_b = 1'b0;
      end else if (rdy) begin
        e_pca = pa; e_ia = ia; ev_a = (ia != 32'h0);
        if (c) begin
          ev_b = 1'b0; held_q.push_back({pa + 32'd4, ib});
          if (e_split != '1) e_split = e_split + 1'b1;
        end else begin
          e_pcb = pa + 32'd4; e_ib = ib; ev_b = (ib != 32'h0);
          if (ev_a && ev_b && e_pair != '1) e_pair = e_pair + 1'b1;
        end
      end
      tick();
      tests_run++; if ({iss_valid_a, iss_valid_b} !== {ev_a, ev_b}) begin tests_failed++;
        $display("FAIL rand_valid[%0d]: got %b want %b", cyc, {iss_valid_a, iss_valid_b}, {ev_a, ev_b}); end
      if (ev_a) begin
        tests_run++; if ({iss_pc_a, iss_instr_a} !== {e_pca, e_ia}) begin tests_failed++;
          $display("FAIL rand_a[%0d]: got %h %h want %h %h", cyc, iss_pc_a, iss_instr_a, e_pca, e_ia); end
      end
      if (ev_b) begin
        tests_run++; if ({iss_pc_b, iss_instr_b} !== {e_pcb, e_ib}) begin tests_failed++;
          $display("FAIL rand_b[%0d]: got %h %h want %h %h", cyc, iss_pc_b, iss_instr_b, e_pcb, e_ib); end
      end
`ifdef SCHED_PERF_CNT_EN
      tests_run++; if ({pair_cnt, split_cnt} !== {e_pair, e_split}) begin tests_failed++;
        $display("FAIL rand_cnt[%0d]: got %0d/%0d want %0d/%0d", cyc, pair_cnt, split_cnt, e_pair, e_split); end
`endif
    end
  endtask

`ifdef SCHED_PERF_CNT_EN
  task automatic test_perf_counters();
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, PC0, ADDI_X1, PC1, ADDI_X2, 1'b1, 1'b0);
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, PC0, ADDI_X5, PC1, ADD_X6, 1'b1, 1'b0);
      tick();
      tick();
    end
    tests_run++; if (pair_cnt !== 32'd4) begin tests_failed++; $display("FAIL perf_pair: got %0d want 4", pair_cnt); end
    tests_run++; if (split_cnt !== 32'd2) begin tests_failed++; $display("FAIL perf_split: got %0d want 2", split_cnt); end
    drive(1'b1, PC0, ADDI_X1, PC1, ADDI_X2, 1'b1, 1'b0);
    #2 rst = 1'b1;
    #1;
    tests_run++; if ({pair_cnt, split_cnt} !== 64'h0) begin tests_failed++; $display("FAIL perf_rst: got %0d/%0d want 0/0", pair_cnt, split_cnt); end
    @(negedge clk);
    rst = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_indep_pair();
    test_raw_split();
    test_rules();
    test_hold_not_ready();
    test_flush_hold();
    test_async_reset();
    test_random();
`ifdef SCHED_PERF_CNT_EN
    test_perf_counters();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
